// File: rtl/board_io_pkg.sv
// board_io_pkg
//   Shared constants and elaboration-time helpers for the board I/O
//   conditioner: default parameter values, width helpers and legality
//   checks used by the top level to reject unusable configurations.
package board_io_pkg;

  localparam int DEF_N_IN            = 5;
  localparam int DEF_N_LED           = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_PWM_W           = 8;
  localparam int DEF_PRESC_DIV       = 64;

  // $clog2 that never returns 0, so a counter always has at least one bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = $clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

  // Debounce counter width: enough to hold DEBOUNCE_CYCLES.
  function automatic int deb_cnt_w(input int cycles);
    return clog2_min1(cycles + 1);
  endfunction

  function automatic bit sync_stages_ok(input int v);
    return v >= 2;
  endfunction

  function automatic bit debounce_cycles_ok(input int v);
    return v >= 1;
  endfunction

  function automatic bit presc_div_ok(input int v);
    return v >= 1;
  endfunction

endpackage

// File: rtl/board_io_debounce.sv
// board_io_debounce
//   One input channel: SYNC_STAGES-deep synchroniser, integrating debounce
//   and registered one-cycle rise/fall pulses.
// Ports:
//   clk_i   reference clock
//   rst_ni  asynchronous active-low reset
//   raw_i   unsynchronised board input
//   in_o    debounced level
//   rise_o  one-cycle pulse on debounced 0->1
//   fall_o  one-cycle pulse on debounced 1->0
module board_io_debounce
  import board_io_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic in_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int              CW       = deb_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   in_q, in_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    in_d   = in_q;
    cnt_d  = '0;
    // Any cycle where the synchronised level agrees with the accepted level
    // clears the count, so a bounce restarts integration from zero.
    if (sync_s != in_q) begin
      if (cnt_q == CNT_LAST) begin
        in_d  = sync_s;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
    // Pulses are registered alongside in_q so they line up with the level.
    rise_d = in_d & ~in_q;
    fall_d = ~in_d & in_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      cnt_q  <= '0;
      in_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      in_q   <= in_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign in_o   = in_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/board_io_conditioner.sv
// board_io_conditioner
//   Front-end between board switches/buttons/LEDs and SoC pad-side signals.
//   Inputs: per-channel synchroniser + debounce + edge pulses.
//   Outputs: shared prescaler and PWM counter, per-LED shadowed duty with
//   static-on override and enable.
// Ports:
//   clk_i         reference clock
//   rst_ni        asynchronous active-low reset
//   raw_i         [N_IN]        unsynchronised board inputs
//   in_o          [N_IN]        debounced levels
//   rise_o        [N_IN]        one-cycle pulse on debounced 0->1
//   fall_o        [N_IN]        one-cycle pulse on debounced 1->0
//   led_duty_i    [N_LED*PWM_W] per-LED duty, LED i at [i*PWM_W +: PWM_W]
//   led_static_i  [N_LED]       1 = LED follows led_en_i, no PWM
//   led_en_i      [N_LED]       LED enable
//   led_o         [N_LED]       registered LED drive
//   pwm_period_o                pulse in the cycle the PWM counter becomes 0
module board_io_conditioner
  import board_io_pkg::*;
#(
  parameter int N_IN            = DEF_N_IN,
  parameter int N_LED           = DEF_N_LED,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PWM_W           = DEF_PWM_W,
  parameter int PRESC_DIV       = DEF_PRESC_DIV
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_IN-1:0]        raw_i,
  output logic [N_IN-1:0]        in_o,
  output logic [N_IN-1:0]        rise_o,
  output logic [N_IN-1:0]        fall_o,
  input  logic [N_LED*PWM_W-1:0] led_duty_i,
  input  logic [N_LED-1:0]       led_static_i,
  input  logic [N_LED-1:0]       led_en_i,
  output logic [N_LED-1:0]       led_o,
  output logic                   pwm_period_o
);

  localparam int               PW         = clog2_min1(PRESC_DIV);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESC_DIV - 1);
  localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
  localparam logic [PWM_W-1:0] PWM_LAST   = '1;
  localparam logic [PWM_W-1:0] PWM_ONE    = PWM_W'(1);

  if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync
    $error("board_io_conditioner: SYNC_STAGES must be >= 2");
  end
  if (!debounce_cycles_ok(DEBOUNCE_CYCLES)) begin : g_bad_deb
    $error("board_io_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (!presc_div_ok(PRESC_DIV)) begin : g_bad_presc
    $error("board_io_conditioner: PRESC_DIV must be >= 1");
  end

  // Input path: one independent channel per raw input.
  for (genvar g = 0; g < N_IN; g++) begin : g_in
    board_io_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .raw_i  (raw_i[g]),
      .in_o   (in_o[g]),
      .rise_o (rise_o[g]),
      .fall_o (fall_o[g])
    );
  end

  // Output path state, shared counter plus per-LED shadow and drive.
  logic [PW-1:0]    presc_q, presc_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic             period_q, period_d;
  logic [PWM_W-1:0] shadow_q [N_LED];
  logic [PWM_W-1:0] shadow_d [N_LED];
  logic [N_LED-1:0] led_q, led_d;
  logic             tick;
  logic             wrap_tick;

  assign tick      = (presc_q == PRESC_LAST);
  // The only tick that moves the counter from all-ones back to 0; duty
  // shadows load here so every period runs with a single duty value.
  assign wrap_tick = tick && (pwm_cnt_q == PWM_LAST);

  always_comb begin
    presc_d   = tick ? '0 : presc_q + PRESC_ONE;
    pwm_cnt_d = tick ? pwm_cnt_q + PWM_ONE : pwm_cnt_q;
    period_d  = wrap_tick;
    led_d     = '0;
    for (int i = 0; i < N_LED; i++) begin
      shadow_d[i] = wrap_tick ? led_duty_i[i*PWM_W +: PWM_W] : shadow_q[i];
      // Enable and static override bypass the shadow so mode changes show
      // up on the very next cycle.
      if (!led_en_i[i]) begin
        led_d[i] = 1'b0;
      end else if (led_static_i[i]) begin
        led_d[i] = 1'b1;
      end else if (shadow_q[i] == PWM_LAST) begin
        led_d[i] = 1'b1;
      end else begin
        led_d[i] = (pwm_cnt_q < shadow_q[i]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      period_q  <= 1'b0;
      led_q     <= '0;
      for (int i = 0; i < N_LED; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      period_q  <= period_d;
      led_q     <= led_d;
      for (int i = 0; i < N_LED; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign led_o        = led_q;
  assign pwm_period_o = period_q;

endmodule

// File: tb/tb_board_io_conditioner.sv
// tb_board_io_conditioner
//   Directed bench for board_io_conditioner with DEBOUNCE_CYCLES=4,
//   PRESC_DIV=2, PWM_W=4, SYNC_STAGES=2. Inputs change 1 time unit after
//   a rising edge; outputs are sampled at that same point.
module tb_board_io_conditioner;

  logic        clk_i;
  logic        rst_ni;
  logic [4:0]  raw_i;
  logic [4:0]  in_o;
  logic [4:0]  rise_o;
  logic [4:0]  fall_o;
  logic [15:0] led_duty_i;
  logic [3:0]  led_static_i;
  logic [3:0]  led_en_i;
  logic [3:0]  led_o;
  logic        pwm_period_o;

  int n_chk;
  int n_err;

  board_io_conditioner #(
    .N_IN            (5),
    .N_LED           (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .PWM_W           (4),
    .PRESC_DIV       (2)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .raw_i        (raw_i),
    .in_o         (in_o),
    .rise_o       (rise_o),
    .fall_o       (fall_o),
    .led_duty_i   (led_duty_i),
    .led_static_i (led_static_i),
    .led_en_i     (led_en_i),
    .led_o        (led_o),
    .pwm_period_o (pwm_period_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Advance until pwm_period_o is seen, bounded to 40 cycles.
  task automatic wait_period();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      if (pwm_period_o) seen = 1'b1;
    end
    chk("wait_period", 32'(seen), 32'd1);
  endtask

  int hi0, hi1, hi2, hi3, per;
  bit bad;

  initial begin
    n_chk        = 0;
    n_err        = 0;
    rst_ni       = 1'b0;
    raw_i        = '0;
    led_duty_i   = '0;
    led_static_i = '0;
    led_en_i     = '0;

    // Reset state
    repeat (3) step();
    chk("rst_in",     32'(in_o),         32'd0);
    chk("rst_rise",   32'(rise_o),       32'd0);
    chk("rst_fall",   32'(fall_o),       32'd0);
    chk("rst_led",    32'(led_o),        32'd0);
    chk("rst_period", 32'(pwm_period_o), 32'd0);
    rst_ni = 1'b1;
    repeat (2) step();

    // Clean press on channel 0: level and pulse exactly 6 edges later
    raw_i[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("press_in_k%0d", k),   32'(in_o[0]),   32'(k >= 6));
      chk($sformatf("press_rise_k%0d", k), 32'(rise_o[0]), 32'(k == 6));
      chk($sformatf("press_fall_k%0d", k), 32'(fall_o[0]), 32'd0);
    end

    // Bounce on channel 1: 1,0,1,0 for 2 cycles each, then hold 1
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      raw_i[1] = (i % 2 == 0);
      repeat (2) begin
        step();
        if (in_o[1] || rise_o[1]) bad = 1'b1;
      end
    end
    chk("bounce_hold", 32'(bad), 32'd0);
    raw_i[1] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("bounce_in_k%0d", k),   32'(in_o[1]),   32'(k >= 6));
      chk($sformatf("bounce_rise_k%0d", k), 32'(rise_o[1]), 32'(k == 6));
    end

    // Release channel 0: fall pulse 6 edges later, no rise
    raw_i[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("rel_fall_k%0d", k), 32'(fall_o[0]), 32'(k == 6));
      chk($sformatf("rel_rise_k%0d", k), 32'(rise_o[0]), 32'd0);
    end
    chk("rel_in", 32'(in_o), 32'b00010);

    // Duty sweep: LED0=5, LED1=0, LED2=15, LED3=5 but disabled
    led_duty_i = {4'd5, 4'd15, 4'd0, 4'd5};
    led_en_i   = 4'b0111;
    wait_period();  // shadows still hold the old value until this wrap
    wait_period();  // shadows now hold the new duties; cnt=0
    hi0 = 0; hi1 = 0; hi2 = 0; hi3 = 0; per = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      hi0 += int'(led_o[0]);
      hi1 += int'(led_o[1]);
      hi2 += int'(led_o[2]);
      hi3 += int'(led_o[3]);
      per += int'(pwm_period_o);
    end
    chk("duty5_high",   32'(hi0), 32'd10);
    chk("duty0_high",   32'(hi1), 32'd0);
    chk("duty15_high",  32'(hi2), 32'd32);
    chk("disabled_high", 32'(hi3), 32'd0);
    chk("period_count", 32'(per), 32'd1);
    chk("period_at_end", 32'(pwm_period_o), 32'd1);

    // Shadow update: duty 5 -> 12 when the counter reaches 3
    hi0 = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 6) led_duty_i[3:0] = 4'd12;
      hi0 += int'(led_o[0]);
    end
    chk("shadow_old_high", 32'(hi0), 32'd10);
    hi0 = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      hi0 += int'(led_o[0]);
    end
    chk("shadow_new_high", 32'(hi0), 32'd24);

    // Mode override on LED1 (duty 0)
    chk("ovr_before", 32'(led_o[1]), 32'd0);
    led_static_i[1] = 1'b1;
    step();
    chk("ovr_static_on", 32'(led_o[1]), 32'd1);
    led_en_i[1] = 1'b0;
    step();
    chk("ovr_en_off", 32'(led_o[1]), 32'd0);

    // Async reset mid-debounce and mid-period
    led_static_i[0] = 1'b1;
    step();
    chk("pre_rst_led0", 32'(led_o[0]), 32'd1);
    raw_i[0] = 1'b1;
    raw_i[2] = 1'b1;
    repeat (3) step();
    #3;
    rst_ni = 1'b0;
    #1;
    chk("arst_in",     32'(in_o),         32'd0);
    chk("arst_rise",   32'(rise_o),       32'd0);
    chk("arst_fall",   32'(fall_o),       32'd0);
    chk("arst_led",    32'(led_o),        32'd0);
    chk("arst_period", 32'(pwm_period_o), 32'd0);
    #2;
    rst_ni = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("post_rise_k%0d", k), 32'(rise_o), (k == 6) ? 32'b00111 : 32'd0);
      chk($sformatf("post_in_k%0d", k),   32'(in_o),   (k >= 6) ? 32'b00111 : 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
